// File: rtl/ex_stage_pkg.sv
// Shared constants and types for the MIPS execute stage: ALU op classes,
// funct codes, mult/div FSM states and engine operation codes.
package ex_pkg;

  localparam int XLEN      = 32;
  localparam int MD_CYCLES = XLEN;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_SLT   = 2'b11;

  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  typedef enum logic {IDLE, RUN} md_state_e;

  typedef enum logic [1:0] {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU} md_op_e;

  function automatic logic is_muldiv(input logic [5:0] fn);
    return (fn == FN_MULT) || (fn == FN_MULTU) || (fn == FN_DIV) || (fn == FN_DIVU);
  endfunction

  function automatic md_op_e md_op_of(input logic [5:0] fn);
    case (fn)
      FN_MULT:  return MD_MULT;
      FN_MULTU: return MD_MULTU;
      FN_DIV:   return MD_DIV;
      default:  return MD_DIVU;
    endcase
  endfunction

endpackage

// File: rtl/ex_stage_if.sv
// ID/EX inputs and EX/MEM outputs of the execute stage, bundled as one port.
interface ex_stage_if;
  import ex_pkg::*;

  logic [XLEN-1:0] readreg1;
  logic [XLEN-1:0] readreg2;
  logic [XLEN-1:0] signextend;
  logic            regwrite;
  logic            regdst;
  logic            alusrc;
  logic            memwrite;
  logic            memread;
  logic            memtoreg;
  logic [1:0]      aluop;
  logic [4:0]      rt;
  logic [4:0]      rd;
  logic [5:0]      func;

  logic [XLEN-1:0] aluresult;
  logic [XLEN-1:0] writedata;
  logic [4:0]      writereg;
  logic            regwriteo;
  logic            memwriteo;
  logic            memreado;
  logic            memtorego;
  logic            busy;

  modport slave (
    input  readreg1, readreg2, signextend, regwrite, regdst, alusrc,
           memwrite, memread, memtoreg, aluop, rt, rd, func,
    output aluresult, writedata, writereg, regwriteo, memwriteo,
           memreado, memtorego, busy
  );

  modport master (
    output readreg1, readreg2, signextend, regwrite, regdst, alusrc,
           memwrite, memread, memtoreg, aluop, rt, rd, func,
    input  aluresult, writedata, writereg, regwriteo, memwriteo,
           memreado, memtorego, busy
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide engine: one shift-add or restoring-divide step per
// cycle on operand magnitudes, signs fixed up on the final step.
module muldiv_unit
  import ex_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            i_start,
  input  md_op_e          i_op,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic            o_busy,
  output logic            o_done,
  output logic [XLEN-1:0] o_hi,
  output logic [XLEN-1:0] o_lo
);
  localparam int CW = $clog2(MD_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(MD_CYCLES - 1);

  md_state_e       r_state, w_stateNext;
  logic [CW-1:0]   r_count, w_countNext;
  md_op_e          r_op;
  logic [XLEN-1:0] r_acc, r_quo, r_div, r_dividend;
  logic            r_negLo, r_negHi, r_divZero;

  logic            w_isMul, w_signed, w_negA, w_negB, w_fits;
  logic [XLEN-1:0] w_magA, w_magB, w_accNext, w_quoNext;
  logic [XLEN:0]   w_mulSum, w_shift;
  logic [2*XLEN-1:0] w_prod;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_count <= '0;
    end else begin
      r_state <= w_stateNext;
      r_count <= w_countNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    w_countNext = r_count;
    o_done      = 1'b0;
    case (r_state)
      IDLE: if (i_start) begin
        w_stateNext = RUN;
        w_countNext = '0;
      end
      RUN: if (r_count == LAST) begin
        w_stateNext = IDLE;
        w_countNext = '0;
        o_done      = 1'b1;
      end else begin
        w_countNext = r_count + 1'b1;
      end
      default: w_stateNext = IDLE;
    endcase
  end

  assign o_busy   = (r_state == RUN);
  assign w_signed = (i_op == MD_MULT) || (i_op == MD_DIV);
  assign w_negA   = w_signed & i_a[XLEN-1];
  assign w_negB   = w_signed & i_b[XLEN-1];
  assign w_magA   = w_negA ? -i_a : i_a;
  assign w_magB   = w_negB ? -i_b : i_b;
  assign w_isMul  = (r_op == MD_MULT) || (r_op == MD_MULTU);

  // Multiply: r_acc:r_quo is the product shifting right; r_quo starts as the multiplier.
  // Divide: r_acc is the partial remainder, r_quo shifts the dividend out and quotient in.
  assign w_mulSum = {1'b0, r_acc} + (r_quo[0] ? {1'b0, r_div} : '0);
  assign w_shift  = {r_acc, r_quo[XLEN-1]};
  assign w_fits   = (w_shift >= {1'b0, r_div});

  always_comb begin
    if (w_isMul) begin
      w_accNext = w_mulSum[XLEN:1];
      w_quoNext = {w_mulSum[0], r_quo[XLEN-1:1]};
    end else begin
      w_accNext = w_fits ? (w_shift[XLEN-1:0] - r_div) : w_shift[XLEN-1:0];
      w_quoNext = {r_quo[XLEN-2:0], w_fits};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op       <= MD_MULT;
      r_acc      <= '0;
      r_quo      <= '0;
      r_div      <= '0;
      r_dividend <= '0;
      r_negLo    <= 1'b0;
      r_negHi    <= 1'b0;
      r_divZero  <= 1'b0;
    end else if (r_state == IDLE && i_start) begin
      r_op       <= i_op;
      r_acc      <= '0;
      r_quo      <= w_magA;
      r_div      <= w_magB;
      r_dividend <= i_a;
      r_negLo    <= w_negA ^ w_negB;
      r_negHi    <= (i_op == MD_MULT) ? (w_negA ^ w_negB) : w_negA;
      r_divZero  <= (i_b == '0) && (i_op == MD_DIV || i_op == MD_DIVU);
    end else if (r_state == RUN) begin
      r_acc <= w_accNext;
      r_quo <= w_quoNext;
    end
  end

  // 0x80000000 / -1 falls out naturally: magnitude quotient 2^31 negates to itself.
  assign w_prod = {w_accNext, w_quoNext};
  always_comb begin
    o_hi = '0;
    o_lo = '0;
    if (w_isMul) begin
      {o_hi, o_lo} = r_negLo ? -w_prod : w_prod;
    end else if (r_divZero) begin
      o_hi = r_dividend;
      o_lo = '1;
    end else begin
      o_hi = r_negHi ? -w_accNext : w_accNext;
      o_lo = r_negLo ? -w_quoNext : w_quoNext;
    end
  end

endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: ALU, HI/LO pair and EX/MEM pipeline register, with a
// multi-cycle mult/div engine that stalls the front of the pipe via busy.
module ex_stage
  import ex_pkg::*;
(
  input logic       clk,
  input logic       rst,
  ex_stage_if.slave bus
);
  logic [XLEN-1:0] r_hi, r_lo;
  logic [XLEN-1:0] w_opB, w_aluResult, w_mdHi, w_mdLo;
  logic            w_busy, w_mdDone, w_isMd, w_start;
  logic [4:0]      w_shamt;

  assign w_opB   = bus.alusrc ? bus.signextend : bus.readreg2;
  assign w_shamt = bus.signextend[10:6];
  assign w_isMd  = (bus.aluop == ALUOP_RTYPE) && is_muldiv(bus.func);
  assign w_start = w_isMd && !w_busy;
  assign bus.busy = w_busy;

  muldiv_unit u_muldiv (
    .clk     (clk),
    .rst     (rst),
    .i_start (w_start),
    .i_op    (md_op_of(bus.func)),
    .i_a     (bus.readreg1),
    .i_b     (bus.readreg2),
    .o_busy  (w_busy),
    .o_done  (w_mdDone),
    .o_hi    (w_mdHi),
    .o_lo    (w_mdLo)
  );

  always_comb begin
    w_aluResult = '0;
    case (bus.aluop)
      ALUOP_ADD: w_aluResult = bus.readreg1 + w_opB;
      ALUOP_SUB: w_aluResult = bus.readreg1 - w_opB;
      ALUOP_SLT: w_aluResult = {31'b0, $signed(bus.readreg1) < $signed(w_opB)};
      default: begin
        case (bus.func)
          FN_ADD:  w_aluResult = bus.readreg1 + w_opB;
          FN_SUB:  w_aluResult = bus.readreg1 - w_opB;
          FN_AND:  w_aluResult = bus.readreg1 & w_opB;
          FN_OR:   w_aluResult = bus.readreg1 | w_opB;
          FN_SLT:  w_aluResult = {31'b0, $signed(bus.readreg1) < $signed(w_opB)};
          FN_SLL:  w_aluResult = bus.readreg2 << w_shamt;
          FN_MFHI: w_aluResult = r_hi;
          FN_MFLO: w_aluResult = r_lo;
          default: w_aluResult = '0;
        endcase
      end
    endcase
  end

  // Both the accepting edge of a mult/div and every busy cycle push a full bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hi          <= '0;
      r_lo          <= '0;
      bus.aluresult <= '0;
      bus.writedata <= '0;
      bus.writereg  <= '0;
      bus.regwriteo <= 1'b0;
      bus.memwriteo <= 1'b0;
      bus.memreado  <= 1'b0;
      bus.memtorego <= 1'b0;
    end else begin
      if (w_mdDone) begin
        r_hi <= w_mdHi;
        r_lo <= w_mdLo;
      end
      if (w_busy || w_isMd) begin
        bus.aluresult <= '0;
        bus.writedata <= '0;
        bus.writereg  <= '0;
        bus.regwriteo <= 1'b0;
        bus.memwriteo <= 1'b0;
        bus.memreado  <= 1'b0;
        bus.memtorego <= 1'b0;
      end else begin
        bus.aluresult <= w_aluResult;
        bus.writedata <= bus.readreg2;
        bus.writereg  <= bus.regdst ? bus.rd : bus.rt;
        bus.regwriteo <= bus.regwrite;
        bus.memwriteo <= bus.memwrite;
        bus.memreado  <= bus.memread;
        bus.memtorego <= bus.memtoreg;
      end
    end
  end

endmodule
